dual_range_sampler: RTL
=======================

// Module: dual_range_sampler
// PURPOSE
//  Drives two ultrasonic rangefinders (trigger/echo type) one after the other.
//  Converts each echo pulse width to an 8-bit distance in cm.
//  Publishes DIST1/DIST2 together as one coherent pair, which feeds the angle/direction stage.
//  Sits directly upstream of the orientation logic in the navigation system.
// PARAMETERS
//  TRIG_CYCLES    500        TRIG high time in CLK cycles (10 us @ 50 MHz)
//  CM_CYCLES      2900       echo-high cycles per 1 cm (58 us @ 50 MHz)
//  TIMEOUT_CYCLES 1900000    max wait for echo rise, and max echo width (38 ms)
//  GAP_CYCLES     500000     quiet time after each sensor before the next trigger (10 ms)
// PORTS
//  CLK     in   1  system clock
//  RST_N   in   1  asynchronous reset, active low
//  EN      in   1  level; when high, pair measurements repeat back-to-back
//  ECHO1   in   1  echo from sensor 1 (asynchronous; 2-FF synchronised inside)
//  ECHO2   in   1  echo from sensor 2 (asynchronous; 2-FF synchronised inside)
//  TRIG1   out  1  trigger pulse to sensor 1
//  TRIG2   out  1  trigger pulse to sensor 2
//  DIST1   out  8  sensor 1 distance, cm; 8'hFF = timeout/out of range
//  DIST2   out  8  sensor 2 distance, cm; 8'hFF = timeout/out of range
//  VALID   out  1  1-cycle pulse; DIST1/DIST2 updated this cycle
//  ERR     out  2  [0]=sensor1 timed out, [1]=sensor2 timed out; held with the pair
// BEHAVIOUR
//  Reset values: TRIG1=TRIG2=0, DIST1=DIST2=8'h00, VALID=0, ERR=2'b00, state IDLE, SEL=0.
//  FSM states: IDLE -> TRIG -> WAIT_RISE -> MEASURE -> GAP -> (TRIG or PUBLISH) -> IDLE.
//   IDLE: if EN=1, clear SEL=0 and go to TRIG. EN is sampled only in IDLE.
//   TRIG: TRIGx high for exactly TRIG_CYCLES, where x = SEL+1. Then go to WAIT_RISE.
//   WAIT_RISE: wait for a synchronised 0->1 edge on ECHOx.
//     An echo already high on entry does not count; a fresh rising edge is required.
//     No edge within TIMEOUT_CYCLES -> record 8'hFF, set ERR[SEL], go to GAP.
//   MEASURE: prescaler counts to CM_CYCLES-1, then wraps; each wrap adds 1 to an 8-bit cm counter.
//     The cm counter saturates at 8'hFE, so a valid reading is never 8'hFF.
//     On the 1->0 echo edge, latch the cm count (partial cm truncated) and go to GAP.
//     Echo high longer than TIMEOUT_CYCLES -> record 8'hFF, set ERR[SEL], go to GAP.
//   GAP: idle for GAP_CYCLES. If SEL=0: set SEL=1, go to TRIG. If SEL=1: go to PUBLISH.
//   PUBLISH: load DIST1, DIST2 and ERR together; VALID=1 for this one cycle; go to IDLE.
//  Pair latency: roughly 2*(TRIG + echo + GAP) cycles. At most one VALID per pair.
//  Outputs hold their last published pair between VALID pulses.
//  Per-sensor scratch results are cleared at the start of each pair.
//  EN falling mid-pair: the pair completes and publishes; the FSM then stays in IDLE.
//  Reset mid-operation: TRIG drops immediately; all counters clear; no VALID is produced.
//  Only one TRIG is high at a time; TRIG1 and TRIG2 are never both high.
//  Delay from echo edge to detection is 2 cycles of sync plus 1 cycle of edge detect.
//  The same delay applies to both edges, so the measured width is unbiased.
// CONFIGURATION
//  AVG_EN defined: each DISTx = (new + prev_x) >> 1.
//    The sum is 9 bits wide; the result is truncated.
//    prev_x is updated only on non-timeout readings.
//    A timeout outputs 8'hFF and leaves prev_x unchanged.
//    The first valid reading after reset outputs the raw value and seeds prev_x.
//  AVG_EN undefined: DISTx is the raw reading. No history registers are built.
// STRUCTURE
//  Package nav_range_pkg holds:
//    state encoding localparams (IDLE, TRIG, WAIT_RISE, MEASURE, GAP, PUBLISH);
//    DIST_TIMEOUT = 8'hFF and DIST_MAX = 8'hFE.
//  Sub-module echo_timer, instantiated once and shared through a mux on SEL, contains:
//    the 2-FF synchroniser and edge detector;
//    the cm prescaler and saturating cm counter;
//    the timeout counter.
//  It takes start/echo and returns done/cm/timeout.
//  The top level holds the FSM, TRIG generation, the GAP counter, output registers and AVG_EN history.
// TESTING (sim params: TRIG_CYCLES=2, CM_CYCLES=4, TIMEOUT_CYCLES=2000, GAP_CYCLES=10)
//  1. EN=1. ECHO1 high 40 cycles, ECHO2 high 100 cycles -> one VALID; DIST1=10, DIST2=25, ERR=00.
//  2. ECHO2 never rises -> DIST2=8'hFF, ERR=2'b10, DIST1 valid, VALID still pulses once.
//  3. ECHO1 high 1500 cycles (375 cm) -> DIST1 saturates at 8'hFE, ERR[0]=0.
//     ECHO1 high 2100 cycles -> DIST1=8'hFF, ERR[0]=1.
//  4. Assert RST_N=0 during MEASURE of sensor 2 -> TRIGs 0 and outputs at reset values at once.
//     No VALID after release until EN restarts a full pair.
//  5. Drop EN during sensor 1 GAP -> sensor 2 still triggers, VALID pulses once, FSM stays IDLE.
//     TRIG1/TRIG2 are never both high (assertion held for the whole run).
//  6. AVG_EN: DIST1 readings 10 then 20 -> outputs 10 then 15.
//     A timeout gives 8'hFF; a following reading of 30 outputs 25.

Source files
------------

// File: rtl/nav_range_pkg.sv
// Shared definitions for the dual ultrasonic range sampler.
//   - FSM state encoding for the pair sequencer
//   - distance code points (timeout marker and saturation ceiling)
//   - avg_dist(): 9-bit sum of two readings, halved and truncated
package nav_range_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TRIG      = 3'd1;
    localparam logic [2:0] WAIT_RISE = 3'd2;
    localparam logic [2:0] MEASURE   = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;
    localparam logic [2:0] PUBLISH   = 3'd5;

    localparam logic [7:0] DIST_TIMEOUT = 8'hFF;
    localparam logic [7:0] DIST_MAX     = 8'hFE;

    function automatic logic [7:0] avg_dist(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return 8'(sum >> 1);
    endfunction

endpackage

// File: rtl/echo_timer.sv
// Echo pulse timer shared by both sensors (the caller muxes the echo line).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : 1-cycle pulse, arms the timer to wait for a fresh rising edge
//   echo       : raw asynchronous echo line (2-FF synchronised here)
//   rise       : 1-cycle pulse, accepted rising edge while armed
//   done       : 1-cycle pulse, cm/timeout valid
//   cm         : distance in cm (DIST_MAX saturated) or DIST_TIMEOUT
//   timeout    : no rising edge in time, or echo high too long
// Both edges see the same sync + edge-detect latency, so the width is unbiased.
// CM_CYCLES must be at least 2.
module echo_timer
    import nav_range_pkg::*;
#(
    parameter int CM_CYCLES      = 2900,
    parameter int TIMEOUT_CYCLES = 1900000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       echo,
    output logic       rise,
    output logic       done,
    output logic [7:0] cm,
    output logic       timeout
);

    localparam int PW = (CM_CYCLES > 2) ? $clog2(CM_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] CM_LAST   = PW'(CM_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX     = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_ARMED = 2'd1;
    localparam logic [1:0] PH_MEAS  = 2'd2;

    logic          sync1_r, sync2_r, prev_r;
    logic          rise_r, fall_r;
    logic [1:0]    phase_r;
    logic [PW-1:0] presc_r;
    logic [TW-1:0] tcnt_r;
    logic [7:0]    cnt_r;
    logic          done_r, tmo_r;
    logic [7:0]    cm_r;

    // Synchroniser plus registered edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= echo;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            rise_r  <= sync2_r & ~prev_r;
            fall_r  <= ~sync2_r & prev_r;
        end
    end

    // Wait-for-rise / measure sequencing with prescaler, cm counter and timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= PH_IDLE;
            presc_r <= '0;
            tcnt_r  <= '0;
            cnt_r   <= 8'h00;
            done_r  <= 1'b0;
            tmo_r   <= 1'b0;
            cm_r    <= 8'h00;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                phase_r <= PH_ARMED;
                presc_r <= '0;
                tcnt_r  <= '0;
                cnt_r   <= 8'h00;
                tmo_r   <= 1'b0;
            end else begin
                case (phase_r)
                    PH_ARMED: begin
                        if (rise_r) begin
                            // The detection cycle is the first counted high cycle.
                            phase_r <= PH_MEAS;
                            presc_r <= PW'(1);
                            tcnt_r  <= TW'(1);
                            cnt_r   <= 8'h00;
                        end else if (tcnt_r == T_WAIT_LAST) begin
                            phase_r <= PH_IDLE;
                            done_r  <= 1'b1;
                            tmo_r   <= 1'b1;
                            cm_r    <= DIST_TIMEOUT;
                        end else begin
                            tcnt_r <= tcnt_r + TW'(1);
                        end
                    end
                    PH_MEAS: begin
                        if (fall_r) begin
                            phase_r <= PH_IDLE;
                            done_r  <= 1'b1;
                            tmo_r   <= 1'b0;
                            cm_r    <= cnt_r;
                        end else if (tcnt_r == T_MAX) begin
                            phase_r <= PH_IDLE;
                            done_r  <= 1'b1;
                            tmo_r   <= 1'b1;
                            cm_r    <= DIST_TIMEOUT;
                        end else begin
                            tcnt_r <= tcnt_r + TW'(1);
                            if (presc_r == CM_LAST) begin
                                presc_r <= '0;
                                if (cnt_r != DIST_MAX) begin
                                    cnt_r <= cnt_r + 8'd1;
                                end
                            end else begin
                                presc_r <= presc_r + PW'(1);
                            end
                        end
                    end
                    default: phase_r <= PH_IDLE;
                endcase
            end
        end
    end

    assign rise    = (phase_r == PH_ARMED) & rise_r & ~start;
    assign done    = done_r;
    assign cm      = cm_r;
    assign timeout = tmo_r;

endmodule

// File: rtl/dual_range_sampler.sv
// Sequences two trigger/echo rangefinders one after the other and publishes
// both distances as one coherent pair with a 1-cycle valid pulse.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : level, repeat pair measurements while high (sampled in IDLE)
//   echo1, echo2 : asynchronous echo inputs
//   trig1, trig2 : trigger pulses, never high together
//   dist1, dist2 : distance in cm, 8'hFF = timeout
//   valid        : 1-cycle pulse when dist1/dist2/err update
//   err          : [0] sensor 1 timed out, [1] sensor 2 timed out
// Build option: define AVG_EN to output the mean of the new and previous
// non-timeout reading per sensor.
module dual_range_sampler
    import nav_range_pkg::*;
#(
    parameter int TRIG_CYCLES    = 500,
    parameter int CM_CYCLES      = 2900,
    parameter int TIMEOUT_CYCLES = 1900000,
    parameter int GAP_CYCLES     = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       echo1,
    input  logic       echo2,
    output logic       trig1,
    output logic       trig2,
    output logic [7:0] dist1,
    output logic [7:0] dist2,
    output logic       valid,
    output logic [1:0] err
);

    localparam int CNT_MAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    logic [2:0]    state_r, next_s;
    logic [CW-1:0] cnt_r;
    logic          sel_r;
    logic [7:0]    raw1_r, raw2_r;
    logic [1:0]    err_scr_r;
    logic          trig1_s, trig2_s, pub_s, et_start_s;
    logic          et_rise_s, et_done_s, et_tmo_s;
    logic [7:0]    et_cm_s;
    logic          echo_mux_s;
    logic [7:0]    out1_s, out2_s;
    logic          trig1_r, trig2_r, valid_r;
    logic [7:0]    dist1_r, dist2_r;
    logic [1:0]    err_r;

    assign echo_mux_s = sel_r ? echo2 : echo1;

    echo_timer #(
        .CM_CYCLES      (CM_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_echo_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (et_start_s),
        .echo    (echo_mux_s),
        .rise    (et_rise_s),
        .done    (et_done_s),
        .cm      (et_cm_s),
        .timeout (et_tmo_s)
    );

    // State register and shared TRIG/GAP cycle counter (cleared on every state change)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= next_s;
            if (next_s != state_r) begin
                cnt_r <= '0;
            end else if ((state_r == TRIG) || (state_r == GAP)) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) next_s = TRIG;
                else    next_s = IDLE;
            end
            TRIG: begin
                if (cnt_r == TRIG_LAST) next_s = WAIT_RISE;
                else                    next_s = TRIG;
            end
            WAIT_RISE: begin
                if (et_done_s)      next_s = GAP;
                else if (et_rise_s) next_s = MEASURE;
                else                next_s = WAIT_RISE;
            end
            MEASURE: begin
                if (et_done_s) next_s = GAP;
                else           next_s = MEASURE;
            end
            GAP: begin
                if (cnt_r == GAP_LAST) next_s = sel_r ? PUBLISH : TRIG;
                else                   next_s = GAP;
            end
            PUBLISH: next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        trig1_s    = 1'b0;
        trig2_s    = 1'b0;
        pub_s      = 1'b0;
        et_start_s = 1'b0;
        case (state_r)
            TRIG: begin
                trig1_s    = ~sel_r;
                trig2_s    = sel_r;
                et_start_s = (cnt_r == TRIG_LAST);
            end
            PUBLISH: pub_s = 1'b1;
            default: pub_s = 1'b0;
        endcase
    end

    // Sensor select and per-pair scratch results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r     <= 1'b0;
            raw1_r    <= 8'h00;
            raw2_r    <= 8'h00;
            err_scr_r <= 2'b00;
        end else if ((state_r == IDLE) && en) begin
            sel_r     <= 1'b0;
            raw1_r    <= 8'h00;
            raw2_r    <= 8'h00;
            err_scr_r <= 2'b00;
        end else begin
            if ((state_r == GAP) && (cnt_r == GAP_LAST) && !sel_r) begin
                sel_r <= 1'b1;
            end
            if (et_done_s) begin
                if (sel_r) begin
                    raw2_r       <= et_cm_s;
                    err_scr_r[1] <= et_tmo_s;
                end else begin
                    raw1_r       <= et_cm_s;
                    err_scr_r[0] <= et_tmo_s;
                end
            end
        end
    end

`ifdef AVG_EN
    logic [7:0] prev1_r, prev2_r;
    logic [1:0] seen_r;

    // Per-sensor history of the last non-timeout reading
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev1_r <= 8'h00;
            prev2_r <= 8'h00;
            seen_r  <= 2'b00;
        end else if (pub_s) begin
            if (!err_scr_r[0]) begin
                prev1_r   <= raw1_r;
                seen_r[0] <= 1'b1;
            end
            if (!err_scr_r[1]) begin
                prev2_r   <= raw2_r;
                seen_r[1] <= 1'b1;
            end
        end
    end

    // Averaged output values; first reading after reset passes through raw
    always_comb begin
        if (err_scr_r[0])   out1_s = DIST_TIMEOUT;
        else if (seen_r[0]) out1_s = avg_dist(raw1_r, prev1_r);
        else                out1_s = raw1_r;
        if (err_scr_r[1])   out2_s = DIST_TIMEOUT;
        else if (seen_r[1]) out2_s = avg_dist(raw2_r, prev2_r);
        else                out2_s = raw2_r;
    end
`else
    // Raw readings go straight to the output registers
    always_comb begin
        out1_s = raw1_r;
        out2_s = raw2_r;
    end
`endif

    // Registered outputs; the pair and its error flags load together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig1_r <= 1'b0;
            trig2_r <= 1'b0;
            valid_r <= 1'b0;
            dist1_r <= 8'h00;
            dist2_r <= 8'h00;
            err_r   <= 2'b00;
        end else begin
            trig1_r <= trig1_s;
            trig2_r <= trig2_s;
            valid_r <= pub_s;
            if (pub_s) begin
                dist1_r <= out1_s;
                dist2_r <= out2_s;
                err_r   <= err_scr_r;
            end
        end
    end

    assign trig1 = trig1_r;
    assign trig2 = trig2_r;
    assign valid = valid_r;
    assign dist1 = dist1_r;
    assign dist2 = dist2_r;
    assign err   = err_r;

endmodule
